// File: rtl/mem_load_arb.sv
// Bus/memory arbiter that freezes the CPU at an instruction boundary and writes loader beats.
// Optional macro LDR_AUTOINC_EN: latch the first beat address and auto-increment it per beat.
module mem_load_arb #(
   parameter int pDATA_WIDTH = 8,
   parameter int pADDR_WIDTH = 8
) (
   input  logic                   iclk,
   input  logic                   irst,
   input  logic                   ien,
   input  logic                   icpu_boundary,
   input  logic                   ild_req,
   input  logic [pADDR_WIDTH-1:0] ild_addr,
   input  logic [pDATA_WIDTH-1:0] ild_data,
   output logic                   old_ack,
   output logic                   ocpu_en,
   output logic                   obus_ovr,
   output logic [pDATA_WIDTH-1:0] obus_data,
   output logic                   oame_en,
   output logic                   odme_en,
   output logic                   obusy,
   output logic [7:0]             obeat_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_LD_ADDR,
      S_LD_DATA,
      S_ACK,
      S_HOLD
   } state_e;

   state_e                 state_q, state_d;
   logic [7:0]             beat_cnt_q, beat_cnt_d;
   logic                   drain_done;
   logic [pADDR_WIDTH-1:0] beat_addr;

   // The CPU may be frozen once it finishes its last step, or at once if it is not running.
   assign drain_done = (state_q == S_DRAIN) && (icpu_boundary || !ien);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (ild_req) state_d = S_DRAIN;
         S_DRAIN:   if (drain_done) state_d = S_LD_ADDR;
         S_LD_ADDR: state_d = S_LD_DATA;
         S_LD_DATA: state_d = S_ACK;
         S_ACK:     state_d = S_HOLD;
         S_HOLD:    state_d = ild_req ? S_LD_ADDR : S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   assign beat_cnt_d = (state_q == S_LD_DATA) ? beat_cnt_q + 8'd1 : beat_cnt_q;

`ifdef LDR_AUTOINC_EN
   localparam logic [pADDR_WIDTH-1:0] ADDR_ONE = 1;

   logic [pADDR_WIDTH-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (drain_done) begin
         addr_d = ild_addr;
      end else if (state_q == S_LD_DATA) begin
         addr_d = addr_q + ADDR_ONE;
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign beat_addr = addr_q;
`else
   assign beat_addr = ild_addr;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Enables decode only from state; ien is the sole pass-through to ocpu_en.
   always_comb begin
      ocpu_en   = 1'b0;
      obus_ovr  = 1'b0;
      obus_data = '0;
      oame_en   = 1'b0;
      odme_en   = 1'b0;
      old_ack   = 1'b0;
      case (state_q)
         S_IDLE, S_DRAIN: ocpu_en = ien;
         S_LD_ADDR: begin
            obus_ovr                       = 1'b1;
            oame_en                        = 1'b1;
            obus_data[pADDR_WIDTH-1:0]     = beat_addr;
         end
         S_LD_DATA: begin
            obus_ovr  = 1'b1;
            odme_en   = 1'b1;
            obus_data = ild_data;
         end
         S_ACK:   old_ack = 1'b1;
         default: ;
      endcase
   end

   assign obusy     = (state_q != S_IDLE);
   assign obeat_cnt = beat_cnt_q;

endmodule
